// File: rtl/gc_sram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// gc_sram_ctrl_pkg
// Shared types and constants for the 1RW SRAM sequencer / arbiter.
//   state_e    : controller state (array initialisation, normal traffic)
//   REQ_READ   : value of reqN_we that requests a read
//   REQ_WRITE  : value of reqN_we that requests a write
//   DEF_ADDR_W : default address width (128 words)
//   DEF_DATA_W : default word width
// ---------------------------------------------------------------------------
package gc_sram_ctrl_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 4;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/gc_rr_arb2.sv
// ---------------------------------------------------------------------------
// gc_rr_arb2
// Two-way round-robin arbiter, purely combinational. The pointer register is
// owned by the parent, which loads next_ptr every cycle.
//   eligible [1:0] in  : requester i may be granted this cycle
//   rr_ptr         in  : preferred requester when both are eligible
//   grant    [1:0] out : one-hot grant (all zero when nobody is eligible)
//   next_ptr       out : pointer value for the next cycle
// ---------------------------------------------------------------------------
module gc_rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       rr_ptr,
    output logic [1:0] grant,
    output logic       next_ptr
);

    // Grant selection; after a grant to i the pointer moves to the other side.
    always_comb begin
        grant    = 2'b00;
        next_ptr = rr_ptr;
        case (eligible)
            2'b01: begin
                grant    = 2'b01;
                next_ptr = 1'b1;
            end
            2'b10: begin
                grant    = 2'b10;
                next_ptr = 1'b0;
            end
            2'b11: begin
                if (rr_ptr == 1'b0) begin
                    grant    = 2'b01;
                    next_ptr = 1'b1;
                end else begin
                    grant    = 2'b10;
                    next_ptr = 1'b0;
                end
            end
            default: begin
                grant    = 2'b00;
                next_ptr = rr_ptr;
            end
        endcase
    end

endmodule

// File: rtl/gc_sram1rw_arbiter.sv
// ---------------------------------------------------------------------------
// gc_sram1rw_arbiter
// Shares one single-port 1RW SRAM macro between two valid/ready requesters and
// returns read data on one shared response channel. After reset the array is
// optionally filled with INIT_VALUE before any request is accepted.
//   clock, reset               : block clock, synchronous active-high reset
//   reqN_valid/we/addr/wdata   : request channel N (we=1 write, we=0 read)
//   reqN_ready                 : request N granted this cycle
//   rsp_valid/ready/id/data    : read response (data passes straight from sram_o)
//   init_done                  : array initialised, traffic allowed
//   sram_csb/web/oeb/a/i       : macro controls (active-low) and address/data
//   sram_o                     : macro read data register
// ---------------------------------------------------------------------------
module gc_sram1rw_arbiter
    import gc_sram_ctrl_pkg::*;
#(
    parameter int                 ADDR_W     = DEF_ADDR_W,
    parameter int                 DATA_W     = DEF_DATA_W,
    parameter bit                 INIT_EN    = 1'b1,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              init_done,
    output logic              sram_csb,
    output logic              sram_web,
    output logic              sram_oeb,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_i,
    input  logic [DATA_W-1:0] sram_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE_ADDR  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            r_state;
    logic [ADDR_W-1:0] r_init_cnt;
    logic              r_init_done;
    logic              r_rsp_valid;
    logic              r_rsp_id;
    logic              r_rr_ptr;

    logic              w_run;
    logic              w_rsp_block;
    logic [1:0]        w_eligible;
    logic [1:0]        w_grant;
    logic              w_next_ptr;
    logic              w_any_gnt;
    logic              w_gnt_we;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;
    logic              w_rd_gnt;

    // Traffic is only granted in RUN and never in a reset cycle.
    assign w_run       = (r_state == ST_RUN) & ~reset;
    // A held response freezes the macro output register, so only reads stall.
    assign w_rsp_block = r_rsp_valid & ~rsp_ready;
    assign w_eligible[0] = w_run & req0_valid & ((req0_we == REQ_WRITE) | ~w_rsp_block);
    assign w_eligible[1] = w_run & req1_valid & ((req1_we == REQ_WRITE) | ~w_rsp_block);

    gc_rr_arb2 u_arb (
        .eligible (w_eligible),
        .rr_ptr   (r_rr_ptr),
        .grant    (w_grant),
        .next_ptr (w_next_ptr)
    );

    assign w_any_gnt   = |w_grant;
    assign w_gnt_we    = w_grant[1] ? req1_we    : req0_we;
    assign w_gnt_addr  = w_grant[1] ? req1_addr  : req0_addr;
    assign w_gnt_wdata = w_grant[1] ? req1_wdata : req0_wdata;
    assign w_rd_gnt    = w_any_gnt & (w_gnt_we == REQ_READ);

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = sram_o;
    assign init_done  = r_init_done;
    assign sram_oeb   = ~r_rsp_valid;

    // Macro drive: init writes, a granted access, or idle (deselected).
    always_comb begin
        sram_csb = 1'b1;
        sram_web = 1'b1;
        sram_a   = '0;
        sram_i   = '0;
        if (reset) begin
            sram_csb = 1'b1;
            sram_web = 1'b1;
        end else if (r_state == ST_INIT) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_a   = r_init_cnt;
            sram_i   = INIT_VALUE;
        end else if (w_any_gnt) begin
            sram_csb = 1'b0;
            sram_web = ~w_gnt_we;
            sram_a   = w_gnt_addr;
            sram_i   = w_gnt_wdata;
        end else begin
            sram_csb = 1'b1;
            sram_web = 1'b1;
        end
    end

    // Controller state, init counter, round-robin pointer and response state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= INIT_EN ? ST_INIT : ST_RUN;
            r_init_cnt  <= '0;
            r_init_done <= ~INIT_EN;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rr_ptr    <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // The last write issues this cycle; the counter stops here.
                    if (r_init_cnt == LAST_ADDR) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + ONE_ADDR;
                    end
                end
                ST_RUN: begin
                    r_rr_ptr <= w_next_ptr;
                    // A new read wins over the clear of a completing response.
                    if (w_rd_gnt) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= w_grant[1];
                    end else if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end else begin
                        r_rsp_valid <= r_rsp_valid;
                    end
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_init_cnt  <= '0;
                    r_init_done <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gc_sram1rw_arbiter.sv
// ---------------------------------------------------------------------------
// tb_gc_sram1rw_arbiter
// Self-checking bench: a behavioural 1RW macro model, a reference memory and a
// response scoreboard. Instance "a" uses INIT_EN=1, instance "b" INIT_EN=0.
// ---------------------------------------------------------------------------
module tb_gc_sram1rw_arbiter;

    localparam int AW    = 7;
    localparam int DW    = 4;
    localparam int DEPTH = 128;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance a signals
    logic          reset, rsp_ready;
    logic          req0_valid, req0_we, req1_valid, req1_we;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_wdata, req1_wdata;
    logic          req0_ready, req1_ready, rsp_valid, rsp_id, init_done;
    logic [DW-1:0] rsp_data, sram_i, sram_o;
    logic          sram_csb, sram_web, sram_oeb;
    logic [AW-1:0] sram_a;

    // Instance b signals
    logic          reset_b, rsp_ready_b;
    logic          req0_valid_b, req0_we_b, req1_valid_b, req1_we_b;
    logic [AW-1:0] req0_addr_b, req1_addr_b;
    logic [DW-1:0] req0_wdata_b, req1_wdata_b;
    logic          req0_ready_b, req1_ready_b, rsp_valid_b, rsp_id_b, init_done_b;
    logic [DW-1:0] rsp_data_b, sram_i_b, sram_o_b;
    logic          sram_csb_b, sram_web_b, sram_oeb_b;
    logic [AW-1:0] sram_a_b;

    logic [DW-1:0] mem_a   [DEPTH];
    logic [DW-1:0] mem_b   [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW:0]   sb_q [$];

    int checks = 0;
    int errors = 0;

    gc_sram1rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1'b1), .INIT_VALUE(4'h0)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .init_done(init_done), .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb),
        .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o)
    );

    gc_sram1rw_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1'b0), .INIT_VALUE(4'h0)) dut_b (
        .clock(clock), .reset(reset_b),
        .req0_valid(req0_valid_b), .req0_ready(req0_ready_b), .req0_we(req0_we_b),
        .req0_addr(req0_addr_b), .req0_wdata(req0_wdata_b),
        .req1_valid(req1_valid_b), .req1_ready(req1_ready_b), .req1_we(req1_we_b),
        .req1_addr(req1_addr_b), .req1_wdata(req1_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b), .rsp_data(rsp_data_b),
        .init_done(init_done_b), .sram_csb(sram_csb_b), .sram_web(sram_web_b), .sram_oeb(sram_oeb_b),
        .sram_a(sram_a_b), .sram_i(sram_i_b), .sram_o(sram_o_b)
    );

    // Behavioural 1RW macros: write or read on the edge when selected.
    always @(posedge clock) begin
        if (!sram_csb) begin
            if (!sram_web) mem_a[sram_a] <= sram_i;
            else           sram_o <= mem_a[sram_a];
        end
        if (!sram_csb_b) begin
            if (!sram_web_b) mem_b[sram_a_b] <= sram_i_b;
            else             sram_o_b <= mem_b[sram_a_b];
        end
    end

    // Scoreboard monitor: every response handshake pops one expected {id,data}.
    always @(negedge clock) begin
        logic [DW:0] exp_v;
        #1;
        if (!reset && rsp_valid && rsp_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected got id=%0d data=%0h want no response", rsp_id, rsp_data);
            end else begin
                exp_v = sb_q.pop_front();
                if ({rsp_id, rsp_data} !== exp_v) begin
                    errors++;
                    $display("FAIL rsp_sb got id=%0d data=%0h want id=%0d data=%0h",
                             rsp_id, rsp_data, exp_v[DW], exp_v[DW-1:0]);
                end
            end
        end
    end

    // One cycle on instance a: drive at negedge, book-keep grants at negedge+2.
    task automatic step(input logic rst,
                        input logic v0, input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic v1, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        input logic rr);
        @(negedge clock);
        reset = rst; rsp_ready = rr;
        req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
        #2;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (req0_valid && req0_ready) begin
                if (req0_we) ref_mem[req0_addr] = req0_wdata;
                else         sb_q.push_back({1'b0, ref_mem[req0_addr]});
            end
            if (req1_valid && req1_ready) begin
                if (req1_we) ref_mem[req1_addr] = req1_wdata;
                else         sb_q.push_back({1'b1, ref_mem[req1_addr]});
            end
        end
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, rr);
    endtask

    task automatic reset_and_init();
        step(1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
        idle(DEPTH, 1'b1);
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 4'h0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b0, 7'h05, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 7'h05, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %0d want 0", init_done); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0d want 0", rsp_valid); end
        checks++; if ({sram_csb, sram_web, sram_oeb} !== 3'b111) begin errors++; $display("FAIL rst_sram_ctl got %b want 111", {sram_csb, sram_web, sram_oeb}); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0d want 0", req0_ready); end
    endtask

    task automatic test_init();
        logic [AW-1:0] ka;
        for (int k = 0; k < DEPTH; k++) begin
            ka = AW'(k);
            step(1'b0, 1'b1, 1'b0, 7'h05, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
            checks++;
            if ({sram_csb, sram_web, sram_a, sram_i, req0_ready, init_done} !== {1'b0, 1'b0, ka, 4'h0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL init_cycle k=%0d got csb=%0d web=%0d a=%0h i=%0h rdy=%0d done=%0d want 0 0 %0h 0 0 0",
                         k, sram_csb, sram_web, sram_a, sram_i, req0_ready, init_done, ka);
            end
        end
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 4'h0;
        step(1'b0, 1'b1, 1'b0, 7'h05, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_rise got %0d want 1", init_done); end
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL init_first_grant got %0d want 1", req0_ready); end
        idle(1, 1'b1);
        checks++; if (rsp_data !== 4'h0) begin errors++; $display("FAIL init_read5 got %0h want 0", rsp_data); end
    endtask

    task automatic test_raw();
        step(1'b0, 1'b1, 1'b1, 7'h10, 4'hA, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL raw_wr_grant got %0d want 1", req0_ready); end
        step(1'b0, 1'b1, 1'b0, 7'h10, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL raw_early_valid got %0d want 0", rsp_valid); end
        idle(1, 1'b1);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, sram_oeb} !== {1'b1, 1'b0, 4'hA, 1'b0}) begin
            errors++;
            $display("FAIL raw_rsp got v=%0d id=%0d d=%0h oeb=%0d want 1 0 a 0", rsp_valid, rsp_id, rsp_data, sram_oeb);
        end
        idle(1, 1'b1);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL raw_clear got %0d want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int p0, p1;
        logic exp0;
        reset_and_init();
        // Only req1 is granted here, which leaves the pointer on req0.
        for (int k = 0; k < 8; k++)
            step(1'b0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1, 1'b1, AW'(k), DW'(k * 3 + 5), 1'b1);
        p0 = 0; p1 = 0;
        for (int n = 0; n < 8; n++) begin
            exp0 = ((n % 2) == 0);
            step(1'b0, 1'b1, 1'b0, AW'(p0), 4'h0, 1'b1, 1'b0, AW'(7 - p1), 4'h0, 1'b1);
            checks++;
            if ({req0_ready, req1_ready} !== {exp0, ~exp0}) begin
                errors++;
                $display("FAIL rr_grant n=%0d got %b want %b", n, {req0_ready, req1_ready}, {exp0, ~exp0});
            end
            if (req0_ready) p0++;
            if (req1_ready) p1++;
        end
        idle(2, 1'b1);
    endtask

    task automatic test_hold();
        logic [DW-1:0] held;
        step(1'b0, 1'b1, 1'b0, 7'h03, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL hold_first_read got %0d want 1", req0_ready); end
        step(1'b0, 1'b1, 1'b0, 7'h11, 4'h0, 1'b1, 1'b1, 7'h7F, 4'h3, 1'b0);
        held = rsp_data;
        checks++;
        if ({rsp_valid, req0_ready, req1_ready, held} !== {1'b1, 1'b0, 1'b1, ref_mem[3]}) begin
            errors++;
            $display("FAIL hold_block got v=%0d r0=%0d r1=%0d d=%0h want 1 0 1 %0h",
                     rsp_valid, req0_ready, req1_ready, held, ref_mem[3]);
        end
        step(1'b0, 1'b1, 1'b0, 7'h11, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0);
        checks++;
        if ({rsp_valid, req0_ready, sram_csb, rsp_data} !== {1'b1, 1'b0, 1'b1, held}) begin
            errors++;
            $display("FAIL hold_stable got v=%0d r0=%0d csb=%0d d=%0h want 1 0 1 %0h",
                     rsp_valid, req0_ready, sram_csb, rsp_data, held);
        end
        step(1'b0, 1'b1, 1'b0, 7'h11, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL hold_release got %0d want 1", req0_ready); end
        step(1'b0, 1'b1, 1'b0, 7'h7F, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL hold_read_7f got %0d want 1", req0_ready); end
        idle(1, 1'b1);
        checks++;
        if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 4'h3}) begin
            errors++;
            $display("FAIL hold_7f_data got v=%0d id=%0d d=%0h want 1 0 3", rsp_valid, rsp_id, rsp_data);
        end
        idle(1, 1'b1);
    endtask

    task automatic test_reset_mid_init();
        logic [AW-1:0] ka;
        // Leave a response pending, then reset over it.
        step(1'b0, 1'b1, 1'b0, 7'h20, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0);
        checks++; if (sram_a !== 7'd39) begin errors++; $display("FAIL mid_cnt39 got %0d want 39", sram_a); end
        step(1'b1, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            ka = AW'(k);
            step(1'b0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b0, 1'b0, 7'h00, 4'h0, 1'b1);
            checks++;
            if ({sram_csb, sram_web, sram_a, rsp_valid, init_done} !== {1'b0, 1'b0, ka, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL mid_reinit k=%0d got csb=%0d web=%0d a=%0h v=%0d done=%0d want 0 0 %0h 0 0",
                         k, sram_csb, sram_web, sram_a, rsp_valid, init_done, ka);
            end
        end
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = 4'h0;
        idle(1, 1'b1);
        checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL mid_done got %0d want 1", init_done); end
    endtask

    task automatic test_no_init();
        @(negedge clock); reset_b = 1'b1;
        @(negedge clock); reset_b = 1'b1;
        #2;
        checks++; if ({init_done_b, rsp_valid_b} !== 2'b10) begin errors++; $display("FAIL noinit_rst got %b want 10", {init_done_b, rsp_valid_b}); end
        @(negedge clock);
        reset_b = 1'b0; rsp_ready_b = 1'b1;
        req1_valid_b = 1'b1; req1_we_b = 1'b0; req1_addr_b = 7'h00;
        #2;
        checks++;
        if ({init_done_b, req1_ready_b, req0_ready_b, sram_csb_b, sram_web_b} !== 5'b11001) begin
            errors++;
            $display("FAIL noinit_grant got %b want 11001", {init_done_b, req1_ready_b, req0_ready_b, sram_csb_b, sram_web_b});
        end
        @(negedge clock);
        req1_valid_b = 1'b0;
        #2;
        checks++;
        if ({rsp_valid_b, rsp_id_b, rsp_data_b} !== {1'b1, 1'b1, 4'h9}) begin
            errors++;
            $display("FAIL noinit_rsp got v=%0d id=%0d d=%0h want 1 1 9", rsp_valid_b, rsp_id_b, rsp_data_b);
        end
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
        reset_b = 1'b1; rsp_ready_b = 1'b1;
        req0_valid_b = 1'b0; req0_we_b = 1'b0; req0_addr_b = '0; req0_wdata_b = '0;
        req1_valid_b = 1'b0; req1_we_b = 1'b0; req1_addr_b = '0; req1_wdata_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            mem_b[k]   = DW'(k) ^ 4'h9;
            ref_mem[k] = 4'h0;
        end

        test_reset();
        test_init();
        test_raw();
        test_round_robin();
        test_hold();
        test_reset_mid_init();
        test_no_init();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
